acc_step: RTL and testbench

- Downstream consumer of the x2 multiply step.
- Accepts one-cycle result pulses (data plus a done strobe) and accumulates NUM_SAMPLES of them into a saturating sum.
- Presents the finished sum to the next stage with a valid/ready handshake.
- The multiply step cannot be stalled, so samples that arrive while a finished sum is still waiting are dropped and flagged.

---
 rtl/acc_step.sv | 175 +++++++++++++++++
 tb/tb_acc_step.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_step.sv
// acc_step: accumulates NUM_SAMPLES one-cycle result pulses into a saturating
// sum and hands that sum downstream over a valid/ready handshake.
//
// The upstream multiply step cannot be stalled. A sample that arrives while a
// finished sum is still waiting is therefore discarded and reported on drop.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   sample strobe (the multiply step's done)
//   in_data    unsigned sample, zero-extended to ACC_W
//   out_data   batch sum, stable while out_valid=1
//   out_valid  batch sum available
//   out_ready  downstream accepts; transfer on out_valid & out_ready
//   out_sat    the batch saturated; qualified by out_valid
//   drop       one-cycle pulse when an input sample was discarded
//   busy       high whenever the FSM is not IDLE
//
// state | meaning
// IDLE  | no batch in progress, waiting for the first sample
// ACCUM | collecting samples 2..NUM_SAMPLES
// HOLD  | finished sum presented, waiting for out_ready
module acc_step #(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 16,
    parameter int NUM_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sat,
    output logic              drop,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(NUM_SAMPLES);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [7:0]         count_q, count_d;
    logic               sat_q, sat_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_sat_q, out_sat_d;
    logic               drop_q, drop_d;
    logic               busy_q, busy_d;

    logic [ACC_W-1:0]   in_ext;
    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   sum_sat;
    logic               sum_ovf;

    assign in_ext   = ACC_W'(in_data);
    // One extra bit catches the carry out; a carry means the sum clamps.
    assign sum_wide = {1'b0, acc_q} + {1'b0, in_ext};
    assign sum_ovf  = sum_wide[ACC_W];
    assign sum_sat  = sum_ovf ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sat_d       = sat_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sat_d   = out_sat_q;
        drop_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = in_ext;
                    count_d = 8'd1;
                    sat_d   = 1'b0;
                    if (NUM_SAMPLES == 1) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        out_data_d  = in_ext;
                        out_sat_d   = 1'b0;
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end

            ACCUM: begin
                if (in_valid) begin
                    acc_d   = sum_sat;
                    count_d = count_q + 8'd1;
                    sat_d   = sat_q | sum_ovf;
                    if (count_q + 8'd1 == LAST_CNT) begin
                        state_d     = HOLD;
                        out_valid_d = 1'b1;
                        out_data_d  = sum_sat;
                        out_sat_d   = sat_q | sum_ovf;
                    end
                end
            end

            HOLD: begin
                if (out_ready) begin
                    if (in_valid) begin
                        // The slot frees on this edge, so the sample starts
                        // the next batch instead of being dropped.
                        acc_d   = in_ext;
                        count_d = 8'd1;
                        sat_d   = 1'b0;
                        if (NUM_SAMPLES == 1) begin
                            state_d     = HOLD;
                            out_valid_d = 1'b1;
                            out_data_d  = in_ext;
                            out_sat_d   = 1'b0;
                        end else begin
                            state_d     = ACCUM;
                            out_valid_d = 1'b0;
                        end
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end else if (in_valid) begin
                    drop_d = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            drop_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
            drop_q      <= drop_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;
    assign drop      = drop_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_acc_step.sv
// Testbench for acc_step. Three instances cover the default configuration,
// a narrow 9-bit accumulator, and single-sample batches. Expected batch sums
// are queued by the stimulus; a monitor compares every presented output
// against the queue head and pops it on each transfer.
module tb_acc_step;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  iv;
    logic [7:0]  id [3];
    logic [2:0]  ordy;
    logic [2:0]  ov;
    logic [2:0]  osat;
    logic [2:0]  drp;
    logic [2:0]  bsy;
    logic [15:0] od0;
    logic [8:0]  od1;
    logic [15:0] od2;

    int checks   = 0;
    int failures = 0;
    int drop_cnt [3];

    // {sat, data} of each expected batch result, per instance
    logic [16:0] exp_q [3][$];

    always #5 clk = ~clk;

    acc_step u_def (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]),
        .out_data(od0), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_sat(osat[0]), .drop(drp[0]), .busy(bsy[0])
    );

    acc_step #(.ACC_W(9), .NUM_SAMPLES(4)) u_narrow (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]),
        .out_data(od1), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_sat(osat[1]), .drop(drp[1]), .busy(bsy[1])
    );

    acc_step #(.NUM_SAMPLES(1)) u_single (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_data(id[2]),
        .out_data(od2), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_sat(osat[2]), .drop(drp[2]), .busy(bsy[2])
    );

    function automatic logic [15:0] get_od(int i);
        case (i)
            0:       return od0;
            1:       return 16'(od1);
            default: return od2;
        endcase
    endfunction

    // Monitor: every cycle an output is presented it must match the head of
    // the expected queue (so it also has to stay stable while held).
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ov[i] === 1'b1) begin
                checks++;
                if (exp_q[i].size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out inst%0d: got data=%0d sat=%0b, none expected",
                             i, get_od(i), osat[i]);
                end else if ({osat[i], get_od(i)} !== exp_q[i][0]) begin
                    failures++;
                    $display("FAIL out_data inst%0d: got data=%0d sat=%0b, want data=%0d sat=%0b",
                             i, get_od(i), osat[i], exp_q[i][0][15:0], exp_q[i][0][16]);
                end
                if (ordy[i] === 1'b1 && exp_q[i].size() != 0)
                    void'(exp_q[i].pop_front());
            end
            if (drp[i] === 1'b1)
                drop_cnt[i]++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse followed by an idle cycle (non-consecutive samples).
    task automatic sample(int i, logic [7:0] d);
        iv[i] = 1'b1;
        id[i] = d;
        cyc();
        iv[i] = 1'b0;
        cyc();
    endtask

    task automatic expect_out(int i, logic sat, logic [15:0] d);
        exp_q[i].push_back({sat, d});
    endtask

    task automatic check_val(string name, int got, int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic drain(int i);
        int n = 0;
        while (exp_q[i].size() != 0 && n < 50) begin
            cyc();
            n++;
        end
        check_val($sformatf("drain_inst%0d_pending", i), exp_q[i].size(), 0);
    endtask

    initial begin
        rst  = 1'b1;
        iv   = '0;
        ordy = '0;
        for (int i = 0; i < 3; i++) begin
            id[i] = '0;
            drop_cnt[i] = 0;
        end
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("rst_out_valid%0d", i), int'(ov[i]), 0);
            check_val($sformatf("rst_out_data%0d", i), int'(get_od(i)), 0);
            check_val($sformatf("rst_busy%0d", i), int'(bsy[i]), 0);
            check_val($sformatf("rst_drop%0d", i), int'(drp[i]), 0);
            check_val($sformatf("rst_sat%0d", i), int'(osat[i]), 0);
        end

        // Basic batch 2+4+6+8, downstream always ready.
        ordy[0] = 1'b1;
        expect_out(0, 1'b0, 16'd20);
        sample(0, 8'd2);
        sample(0, 8'd4);
        sample(0, 8'd6);
        iv[0] = 1'b1; id[0] = 8'd8;
        cyc();
        iv[0] = 1'b0;
        check_val("basic_valid_after_last", int'(ov[0]), 1);
        cyc();
        check_val("basic_valid_one_cycle", int'(ov[0]), 0);
        check_val("basic_back_idle", int'(bsy[0]), 0);

        // Saturating 9-bit accumulator, then a clean batch clears sat.
        ordy[1] = 1'b1;
        expect_out(1, 1'b1, 16'd511);
        for (int k = 0; k < 4; k++) sample(1, 8'd254);
        expect_out(1, 1'b0, 16'd4);
        for (int k = 0; k < 4; k++) sample(1, 8'd1);
        drain(1);

        // Held output with two discarded samples.
        ordy[0] = 1'b0;
        expect_out(0, 1'b0, 16'd4);
        for (int k = 0; k < 4; k++) sample(0, 8'd1);
        iv[0] = 1'b1; id[0] = 8'd9;
        cyc();
        iv[0] = 1'b0;
        cyc();
        iv[0] = 1'b1; id[0] = 8'd9;
        cyc();
        iv[0] = 1'b0;
        cyc();
        check_val("hold_still_valid", int'(ov[0]), 1);
        check_val("hold_drop_count", drop_cnt[0], 2);
        ordy[0] = 1'b1;
        cyc();
        cyc();
        check_val("hold_release_idle", int'(bsy[0]), 0);

        // Handshake and first sample of the next batch on the same edge.
        ordy[0] = 1'b0;
        expect_out(0, 1'b0, 16'd10);
        sample(0, 8'd1);
        sample(0, 8'd2);
        sample(0, 8'd3);
        sample(0, 8'd4);
        expect_out(0, 1'b0, 16'd10);
        ordy[0] = 1'b1;
        iv[0] = 1'b1; id[0] = 8'd7;
        cyc();
        iv[0] = 1'b0;
        check_val("overlap_busy_accum", int'(bsy[0]), 1);
        for (int k = 0; k < 3; k++) sample(0, 8'd1);
        drain(0);
        check_val("overlap_no_drop", drop_cnt[0], 2);

        // Reset mid-batch discards the partial sum.
        sample(0, 8'd5);
        sample(0, 8'd5);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_val("midrst_valid", int'(ov[0]), 0);
        check_val("midrst_busy", int'(bsy[0]), 0);
        check_val("midrst_data", int'(od0), 0);
        expect_out(0, 1'b0, 16'd12);
        for (int k = 0; k < 4; k++) sample(0, 8'd3);
        drain(0);

        // Single-sample batches back to back.
        ordy[2] = 1'b1;
        expect_out(2, 1'b0, 16'd1);
        expect_out(2, 1'b0, 16'd2);
        expect_out(2, 1'b0, 16'd3);
        iv[2] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            id[2] = 8'(k);
            cyc();
            check_val($sformatf("single_valid_%0d", k), int'(ov[2]), 1);
        end
        iv[2] = 1'b0;
        cyc();
        check_val("single_valid_end", int'(ov[2]), 0);
        drain(2);

        check_val("drops_inst0", drop_cnt[0], 2);
        check_val("drops_inst1", drop_cnt[1], 0);
        check_val("drops_inst2", drop_cnt[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
